// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns HI/LO. Define MDU_MADD_EN to add the
// MADD/MADDU/MSUB/MSUBU accumulate ops; without it those encodings act as NOP.
//
// state  | meaning
// IDLE   | accepts MULT/DIV class ops and MTHI/MTLO
// BUSY   | operation in flight, counter runs down to the HI/LO update
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  mdop_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Result is formed from the latched operands and the HI/LO present at the completion edge.
  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
  logic [63:0] res_hilo;
  logic        res_wr;

  always_comb begin
    sgn = 1'b0;
    case (op_q)
      OP_MULT, OP_DIV: sgn = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: sgn = 1'b1;
`endif
      default: sgn = 1'b0;
    endcase
  end

  always_comb begin
    ext_a   = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b   = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod    = ext_a * ext_b;
    // Sign-magnitude divide: handles 0x80000000 / -1 without a special case.
    a_mag   = (sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
    b_mag   = (sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;
    div_den = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / div_den;
    r_mag   = a_mag % div_den;
    quot    = (sgn && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
    rem     = (sgn && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    res_hilo = {hi_q, lo_q};
    res_wr   = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hilo = prod;
        res_wr   = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hilo = {rem, quot};
        res_wr   = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        res_hilo = {hi_q, lo_q} + prod;
        res_wr   = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        res_hilo = {hi_q, lo_q} - prod;
        res_wr   = 1'b1;
      end
`endif
      default: res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (is_long_op(mdop_i)) begin
            a_d     = a_i;
            b_d     = b_i;
            op_d    = mdop_i;
            cnt_d   = is_div_op(mdop_i) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            state_d = S_BUSY;
          end else if (mdop_i == OP_MTHI) begin
            hi_d = a_i;
          end else if (mdop_i == OP_MTLO) begin
            lo_d = a_i;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          if (res_wr) begin
            hi_d = res_hilo[63:32];
            lo_d = res_hilo[31:0];
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o  = (state_q == S_BUSY);
  assign stall_o = busy_o | (start_i & is_long_op(mdop_i));
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed literal cases plus random ops
// checked every cycle against a behavioural HI/LO model.
module tb_mult_div_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  mdop = '0;
  logic        start = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk_i(clk), .reset_i(reset), .a_i(a), .b_i(b), .mdop_i(mdop),
    .start_i(start), .busy_o(busy), .stall_o(stall), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  bit          m_busy;
  int          m_left;

  function automatic bit long_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  function automatic bit signed_op(input logic [3:0] op);
    return op == 4'd1 || op == 4'd3 || op == 4'd7 || op == 4'd9;
  endfunction

  task automatic model_finish();
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa = signed_op(m_op) ? longint'($signed(m_a)) : longint'({32'b0, m_a});
    sb = signed_op(m_op) ? longint'($signed(m_b)) : longint'({32'b0, m_b});
    p = 64'(sa * sb);
    acc = {m_hi, m_lo};
    case (m_op)
      4'd1, 4'd2: {m_hi, m_lo} = p;
      4'd3, 4'd4: if (m_b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd7, 4'd8: {m_hi, m_lo} = acc + p;
      4'd9, 4'd10: {m_hi, m_lo} = acc - p;
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_left = 0; m_op = 0; m_a = 0; m_b = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        model_finish();
      end
    end else if (start) begin
      if (long_op(mdop)) begin
        m_busy = 1;
        m_op = mdop; m_a = a; m_b = b;
        m_left = (mdop == 4'd3 || mdop == 4'd4) ? DIV_N : MUL_N;
      end else if (mdop == 4'd5) m_hi = a;
      else if (mdop == 4'd6) m_lo = a;
    end
  end

  always @(posedge clk) begin
    #1;
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  always @(negedge clk) begin
    check("stall", {31'b0, stall}, {31'b0, m_busy | (start & long_op(mdop))});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1; mdop = op; a = aa; b = bb;
    tick();
    start = 1'b0; mdop = 4'd0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL busy_timeout: busy still high after %0d cycles expected low", n);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] aa,
                        input logic [31:0] bb, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, aa, bb);
    wait_idle(n);
    check({name, "_cycles"}, n, exp_n);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    tick();

    run_op("mult_neg1x2", 4'd1, 32'hFFFFFFFF, 32'd2, MUL_N, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu_ffx2", 4'd2, 32'hFFFFFFFF, 32'd2, MUL_N, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_m7_2", 4'd3, 32'hFFFFFFF9, 32'd2, DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_2", 4'd4, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h0, 32'h80000000);

    issue(4'd5, 32'h11, 32'h0);
    issue(4'd6, 32'h22, 32'h0);
    run_op("divu_by0", 4'd4, 32'd99, 32'd0, DIV_N, 32'h11, 32'h22);

    // MTLO while a MULT is in flight must be dropped
    issue(4'd1, 32'd3, 32'd4);
    start = 1'b1; mdop = 4'd6; a = 32'd5;
    tick();
    start = 1'b0; mdop = 4'd0;
    wait_idle(n);
    check("mult_mtlo_cycles", n, MUL_N - 1);
    check("mult_mtlo_lo", lo, 32'd12);
    check("mult_mtlo_hi", hi, 32'd0);

    start = 1'b1; mdop = 4'd5; a = 32'hABCD;
    tick();
    check("mthi_busy", {31'b0, busy}, 32'h0);
    mdop = 4'd6; a = 32'h1234;
    tick();
    start = 1'b0; mdop = 4'd0;
    check("mtlo_busy", {31'b0, busy}, 32'h0);
    check("mthi_val", hi, 32'hABCD);
    check("mtlo_val", lo, 32'h1234);

    start = 1'b1; mdop = 4'hF; a = 32'h5A5A;
    #3;
    check("undef_stall", {31'b0, stall}, 32'h0);
    tick();
    start = 1'b0; mdop = 4'd0;
    check("undef_busy", {31'b0, busy}, 32'h0);
    check("undef_hi", hi, 32'hABCD);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd10, 32'd0);
    run_op("madd", 4'd7, 32'd3, 32'd4, MUL_N, 32'd0, 32'd22);
    run_op("msubu", 4'd10, 32'd1, 32'd23, MUL_N, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    start = 1'b1; mdop = 4'd7; a = 32'd3; b = 32'd4;
    #3;
    check("madd_off_stall", {31'b0, stall}, 32'h0);
    tick();
    start = 1'b0; mdop = 4'd0;
    check("madd_off_busy", {31'b0, busy}, 32'h0);
`endif

    // reset in the middle of a MULT
    issue(4'd1, 32'd3, 32'd4);
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_after_hi", hi, 32'h0);
    check("rst_after_lo", lo, 32'h0);
    check("rst_after_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 9) < 6);
      mdop  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) mdop = 4'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9)); end
        3: a = 32'h80000000;
        default: ;
      endcase
      tick();
    end
    start = 1'b0; mdop = 4'd0;
    wait_idle(n);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
